mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//  Parametrised MEM->WB pipeline register, DEPTH register stages deep (DEPTH=1 is a plain
//  MEM/WB latch). Carries ALU result, data-memory read data, write-back select and dest reg.
//  Adds valid, stall, flush, the final WB data mux, WB->ID forwarding compares and a retire counter.
//  Sits between the data memory stage and the register file write port.
// PARAMETERS
//  DW      32  width of ALU result, DM read data and WB data
//  RW      5   width of register index (rd, rs1, rs2)
//  DEPTH   1   number of register stages, legal 1..4; other values: $error at elaboration
//  CNT_W   32  width of retire counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  mem_valid     in   1      MEM stage holds a real instruction
//  mem_alu_res   in   DW     ALU result from MEM
//  mem_dm_q      in   DW     data-memory read data from MEM
//  mem_rf_d_sel  in   1      WB source: 0=ALU result, 1=DM data
//  mem_rf_we     in   1      instruction writes register file
//  mem_rd        in   RW     destination register index
//  stall         in   1      hold every stage
//  flush         in   1      kill every in-flight instruction
//  id_rs1        in   RW     ID-stage source 1 index (forward compare)
//  id_rs2        in   RW     ID-stage source 2 index
//  wb_valid      out  1      last stage holds a real instruction
//  wb_data       out  DW     selected write-back data
//  wb_rd         out  RW     destination register at last stage
//  wb_we         out  1      register-file write strobe
//  fwd_a         out  1      id_rs1 matches an active WB write
//  fwd_b         out  1      id_rs2 matches an active WB write
//  retired       out  CNT_W  count of instructions leaving WB
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage payloads, valids and retired -> 0; so wb_valid=0,
//    wb_data=0, wb_rd=0, wb_we=0, fwd_a=fwd_b=0. Deassertion takes effect at next posedge.
//  - Stage k (0..DEPTH-1) register: {valid, alu_res, dm_q, d_sel, we, rd}. Stage 0 loads mem_*,
//    stage k loads stage k-1. Latency mem_* -> wb_* = DEPTH cycles.
//  - Priority per posedge: flush > stall > advance.
//     flush=1: all valid bits <- 0, payloads unchanged (don't care), retired unchanged.
//     stall=1 (flush=0): every stage holds, retired unchanged.
//     else: shift; retired += 1 when last stage valid before the edge (instruction leaves).
//  - retired wraps modulo 2^CNT_W (max -> 0), no saturation.
//  - wb_data combinational from last stage: d_sel ? dm_q : alu_res (independent of valid).
//  - wb_we = wb_valid & we & (wb_rd != 0); writes to r0 never strobe.
//  - wb_we asserted while stall=1 is held steady; the register file write is idempotent.
//  - fwd_a = wb_we & (id_rs1 == wb_rd); fwd_b likewise; combinational, last stage only.
//  - Bubbles: mem_valid=0 enters as valid=0; its we is ignored downstream.
//  - Reset mid-stream discards all in-flight instructions; no partial writes follow.
// TESTING
//  1 DEPTH=1: mem_valid=1, alu_res=0x1234, d_sel=0, we=1, rd=5 -> 1 clk later wb_data=0x1234,
//    wb_we=1, wb_rd=5; retired=1 after following edge.
//  2 DEPTH=3: push dm_q=0xDEADBEEF, d_sel=1, rd=7 -> wb_data=0xDEADBEEF exactly 3 clks later,
//    wb_valid=0 in the two cycles before.
//  3 stall=1 for 4 cycles with valid in last stage -> wb_* constant, retired constant;
//    stall+flush same cycle -> all valid=0 next edge, retired unchanged.
//  4 rd=0, we=1, valid=1 -> wb_we=0, fwd_a=0 with id_rs1=0; rd=9, id_rs1=9, id_rs2=3 ->
//    fwd_a=1, fwd_b=0.
//  5 CNT_W=4: retire 17 instructions -> retired=1 (wrap at 16).
//  6 rst_n pulsed low mid-cycle with 3 valid stages -> outputs 0 immediately (no clk edge),
//    no wb_we after release until new instruction traverses DEPTH stages.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - parametrised MEM->WB pipeline register with WB mux, forwarding and retire count
module mem_wb_pipe #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int DEPTH = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic [DW-1:0]    mem_alu_res,
  input  logic [DW-1:0]    mem_dm_q,
  input  logic             mem_rf_d_sel,
  input  logic             mem_rf_we,
  input  logic [RW-1:0]    mem_rd,
  input  logic             stall,
  input  logic             flush,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  output logic             wb_valid,
  output logic [DW-1:0]    wb_data,
  output logic [RW-1:0]    wb_rd,
  output logic             wb_we,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [CNT_W-1:0] retired
);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("mem_wb_pipe: DEPTH must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic [DW-1:0] alu_res;
    logic [DW-1:0] dm_q;
    logic          d_sel;
    logic          we;
    logic [RW-1:0] rd;
  } stage_t;

  logic [DEPTH-1:0] valid_q;
  stage_t           stage_q [DEPTH];
  stage_t           stage_in;

  assign stage_in = '{alu_res: mem_alu_res, dm_q: mem_dm_q, d_sel: mem_rf_d_sel,
                      we: mem_rf_we, rd: mem_rd};

  // Flush only clears valids; payloads are don't-care once their valid is gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      retired <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= mem_valid;
      stage_q[0] <= stage_in;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        stage_q[k] <= stage_q[k-1];
      end
      if (valid_q[DEPTH-1]) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign wb_valid = valid_q[DEPTH-1];
  assign wb_rd    = stage_q[DEPTH-1].rd;
  assign wb_data  = stage_q[DEPTH-1].d_sel ? stage_q[DEPTH-1].dm_q : stage_q[DEPTH-1].alu_res;
  assign wb_we    = wb_valid & stage_q[DEPTH-1].we & (wb_rd != '0);
  assign fwd_a    = wb_we & (id_rs1 == wb_rd);
  assign fwd_b    = wb_we & (id_rs2 == wb_rd);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - directed-vector bench for mem_wb_pipe at DEPTH=1 and DEPTH=3/CNT_W=4
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_rf_d_sel, mem_rf_we, stall, flush;
  logic [31:0] mem_alu_res, mem_dm_q;
  logic [4:0]  mem_rd, id_rs1, id_rs2;

  logic        d1_wb_valid, d1_wb_we, d1_fwd_a, d1_fwd_b;
  logic [31:0] d1_wb_data, d1_retired;
  logic [4:0]  d1_wb_rd;
  logic        d3_wb_valid, d3_wb_we, d3_fwd_a, d3_fwd_b;
  logic [31:0] d3_wb_data;
  logic [4:0]  d3_wb_rd;
  logic [3:0]  d3_retired;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DW(32), .RW(5), .DEPTH(1), .CNT_W(32)) u_d1 (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_alu_res(mem_alu_res),
    .mem_dm_q(mem_dm_q), .mem_rf_d_sel(mem_rf_d_sel), .mem_rf_we(mem_rf_we),
    .mem_rd(mem_rd), .stall(stall), .flush(flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .wb_valid(d1_wb_valid), .wb_data(d1_wb_data), .wb_rd(d1_wb_rd), .wb_we(d1_wb_we),
    .fwd_a(d1_fwd_a), .fwd_b(d1_fwd_b), .retired(d1_retired)
  );

  mem_wb_pipe #(.DW(32), .RW(5), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_alu_res(mem_alu_res),
    .mem_dm_q(mem_dm_q), .mem_rf_d_sel(mem_rf_d_sel), .mem_rf_we(mem_rf_we),
    .mem_rd(mem_rd), .stall(stall), .flush(flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .wb_valid(d3_wb_valid), .wb_data(d3_wb_data), .wb_rd(d3_wb_rd), .wb_we(d3_wb_we),
    .fwd_a(d3_fwd_a), .fwd_b(d3_fwd_b), .retired(d3_retired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] dm,
                       input logic sel, input logic we, input logic [4:0] rd);
    mem_valid = v; mem_alu_res = alu; mem_dm_q = dm;
    mem_rf_d_sel = sel; mem_rf_we = we; mem_rd = rd;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    stall = 1'b0; flush = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31);
    step();
    rst_n = 1'b0;
    #1;
    vectors++; if (d1_wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_d1_valid got %b want 0", d1_wb_valid); end
    vectors++; if (d1_wb_data !== 32'h0) begin miscompares++; $display("FAIL rst_d1_data got %h want 0", d1_wb_data); end
    vectors++; if (d1_wb_rd !== 5'd0) begin miscompares++; $display("FAIL rst_d1_rd got %0d want 0", d1_wb_rd); end
    vectors++; if ({d1_wb_we, d1_fwd_a, d1_fwd_b} !== 3'b000) begin miscompares++; $display("FAIL rst_d1_we_fwd got %b want 000", {d1_wb_we, d1_fwd_a, d1_fwd_b}); end
    vectors++; if (d1_retired !== 32'd0) begin miscompares++; $display("FAIL rst_d1_retired got %0d want 0", d1_retired); end
    vectors++; if ({d3_wb_valid, d3_wb_we, d3_retired} !== 6'd0) begin miscompares++; $display("FAIL rst_d3 got %b want 0", {d3_wb_valid, d3_wb_we, d3_retired}); end
    do_reset();
  endtask

  task automatic test_depth1();
    do_reset();
    drive(1'b1, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    vectors++; if (d1_wb_valid !== 1'b1) begin miscompares++; $display("FAIL d1_valid got %b want 1", d1_wb_valid); end
    vectors++; if (d1_wb_data !== 32'h1234) begin miscompares++; $display("FAIL d1_data got %h want 00001234", d1_wb_data); end
    vectors++; if (d1_wb_rd !== 5'd5) begin miscompares++; $display("FAIL d1_rd got %0d want 5", d1_wb_rd); end
    vectors++; if (d1_wb_we !== 1'b1) begin miscompares++; $display("FAIL d1_we got %b want 1", d1_wb_we); end
    vectors++; if (d1_retired !== 32'd0) begin miscompares++; $display("FAIL d1_retired_pre got %0d want 0", d1_retired); end
    step();
    vectors++; if (d1_retired !== 32'd1) begin miscompares++; $display("FAIL d1_retired_post got %0d want 1", d1_retired); end
    vectors++; if (d1_wb_valid !== 1'b0) begin miscompares++; $display("FAIL d1_bubble_valid got %b want 0", d1_wb_valid); end
  endtask

  task automatic test_depth3();
    do_reset();
    drive(1'b1, 32'h5555, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    vectors++; if (d3_wb_valid !== 1'b0) begin miscompares++; $display("FAIL d3_lat1_valid got %b want 0", d3_wb_valid); end
    step();
    vectors++; if (d3_wb_valid !== 1'b0) begin miscompares++; $display("FAIL d3_lat2_valid got %b want 0", d3_wb_valid); end
    step();
    vectors++; if (d3_wb_valid !== 1'b1) begin miscompares++; $display("FAIL d3_lat3_valid got %b want 1", d3_wb_valid); end
    vectors++; if (d3_wb_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL d3_data got %h want deadbeef", d3_wb_data); end
    vectors++; if (d3_wb_rd !== 5'd7) begin miscompares++; $display("FAIL d3_rd got %0d want 7", d3_wb_rd); end
    vectors++; if (d3_wb_we !== 1'b1) begin miscompares++; $display("FAIL d3_we got %b want 1", d3_wb_we); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(1'b1, 32'hA5A5, 32'h0, 1'b0, 1'b1, 5'd3);
    step();
    drive(1'b1, 32'h7777, 32'h0, 1'b0, 1'b1, 5'd12);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if ({d1_wb_valid, d1_wb_we, d1_wb_rd, d1_wb_data} !== {1'b1, 1'b1, 5'd3, 32'hA5A5}) begin miscompares++; $display("FAIL stall_hold[%0d] got v=%b we=%b rd=%0d data=%h want v=1 we=1 rd=3 data=0000a5a5", i, d1_wb_valid, d1_wb_we, d1_wb_rd, d1_wb_data); end
      vectors++; if (d1_retired !== 32'd0) begin miscompares++; $display("FAIL stall_retired[%0d] got %0d want 0", i, d1_retired); end
    end
    flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    vectors++; if ({d1_wb_valid, d1_wb_we} !== 2'b00) begin miscompares++; $display("FAIL flush_d1 got v=%b we=%b want 00", d1_wb_valid, d1_wb_we); end
    vectors++; if (d1_retired !== 32'd0) begin miscompares++; $display("FAIL flush_retired got %0d want 0", d1_retired); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (d3_wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_d3_valid[%0d] got %b want 0", i, d3_wb_valid); end
    end
    vectors++; if (d1_retired !== 32'd0) begin miscompares++; $display("FAIL flush_retired_after got %0d want 0", d1_retired); end
  endtask

  task automatic test_fwd();
    do_reset();
    drive(1'b1, 32'h11, 32'h0, 1'b0, 1'b1, 5'd0);
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    step();
    vectors++; if ({d1_wb_valid, d1_wb_we, d1_fwd_a} !== 3'b100) begin miscompares++; $display("FAIL r0_write got v/we/fa=%b want 100", {d1_wb_valid, d1_wb_we, d1_fwd_a}); end
    drive(1'b1, 32'h22, 32'h0, 1'b0, 1'b1, 5'd9);
    id_rs1 = 5'd9; id_rs2 = 5'd3;
    step();
    vectors++; if ({d1_wb_we, d1_fwd_a, d1_fwd_b} !== 3'b110) begin miscompares++; $display("FAIL fwd_rs1 got we/fa/fb=%b want 110", {d1_wb_we, d1_fwd_a, d1_fwd_b}); end
    id_rs2 = 5'd9;
    #1;
    vectors++; if (d1_fwd_b !== 1'b1) begin miscompares++; $display("FAIL fwd_rs2_comb got %b want 1", d1_fwd_b); end
    drive(1'b0, 32'h33, 32'h0, 1'b0, 1'b1, 5'd9);
    step();
    vectors++; if ({d1_wb_we, d1_fwd_a, d1_fwd_b} !== 3'b000) begin miscompares++; $display("FAIL bubble_we got we/fa/fb=%b want 000", {d1_wb_we, d1_fwd_a, d1_fwd_b}); end
    drive(1'b1, 32'h44, 32'h0, 1'b0, 1'b0, 5'd9);
    step();
    vectors++; if ({d1_wb_valid, d1_wb_we, d1_fwd_a} !== 3'b100) begin miscompares++; $display("FAIL no_we got v/we/fa=%b want 100", {d1_wb_valid, d1_wb_we, d1_fwd_a}); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'(i), 32'h0, 1'b0, 1'b1, 5'd1);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    step();
    vectors++; if (d3_retired !== 4'd15) begin miscompares++; $display("FAIL wrap_15 got %0d want 15", d3_retired); end
    vectors++; if (d3_wb_data !== 32'd15) begin miscompares++; $display("FAIL b2b_data got %0d want 15", d3_wb_data); end
    step();
    vectors++; if (d3_retired !== 4'd0) begin miscompares++; $display("FAIL wrap_0 got %0d want 0", d3_retired); end
    step();
    vectors++; if (d3_retired !== 4'd1) begin miscompares++; $display("FAIL wrap_1 got %0d want 1", d3_retired); end
    vectors++; if (d1_retired !== 32'd17) begin miscompares++; $display("FAIL d1_retired_17 got %0d want 17", d1_retired); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'h0, 1'b0, 1'b1, 5'd4 + 5'(i));
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    vectors++; if ({d3_wb_valid, d3_wb_we, d3_wb_rd} !== {1'b1, 1'b1, 5'd4}) begin miscompares++; $display("FAIL mid_pre got v=%b we=%b rd=%0d want v=1 we=1 rd=4", d3_wb_valid, d3_wb_we, d3_wb_rd); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({d3_wb_valid, d3_wb_we, d3_wb_data} !== 34'd0) begin miscompares++; $display("FAIL mid_async_d3 got v=%b we=%b data=%h want 0", d3_wb_valid, d3_wb_we, d3_wb_data); end
    vectors++; if (d1_retired !== 32'd0) begin miscompares++; $display("FAIL mid_async_retired got %0d want 0", d1_retired); end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({d3_wb_we, d1_wb_we} !== 2'b00) begin miscompares++; $display("FAIL mid_idle_we[%0d] got %b want 00", i, {d3_wb_we, d1_wb_we}); end
    end
    drive(1'b1, 32'hBEEF, 32'h0, 1'b0, 1'b1, 5'd8);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    vectors++; if (d3_wb_we !== 1'b0) begin miscompares++; $display("FAIL mid_new1 got %b want 0", d3_wb_we); end
    step();
    vectors++; if (d3_wb_we !== 1'b0) begin miscompares++; $display("FAIL mid_new2 got %b want 0", d3_wb_we); end
    step();
    vectors++; if ({d3_wb_we, d3_wb_rd, d3_wb_data} !== {1'b1, 5'd8, 32'hBEEF}) begin miscompares++; $display("FAIL mid_new3 got we=%b rd=%0d data=%h want we=1 rd=8 data=0000beef", d3_wb_we, d3_wb_rd, d3_wb_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    #12;
    rst_n = 1'b1;
    test_reset();
    test_depth1();
    test_depth3();
    test_stall_flush();
    test_fwd();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
